// File: rtl/io_bus_pkg.sv
// Shared definitions for the PIC-to-device IO link: register map, transfer direction,
// IRQ handshake states and the unmapped-read marker (used when IO_SLAVE_RESPONDER_ERRIRQ_EN is set).
package io_bus_pkg;

    localparam logic [31:0] REG_ID           = 32'h0000_0000;
    localparam logic [31:0] REG_SIZE         = 32'h0000_0004;
    localparam logic [31:0] REG_PEND         = 32'h0000_0008;
    localparam logic [31:0] REG_MASK         = 32'h0000_000C;
    localparam logic [31:0] REG_SCRATCH_BASE = 32'h0000_0010;
    localparam logic [31:0] REG_SCRATCH_LAST = 32'h0000_001C;

    localparam logic IO_RW_READ  = 1'b0;
    localparam logic IO_RW_WRITE = 1'b1;

    localparam logic [31:0] IO_UNMAPPED_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IRQ_IDLE   = 2'd0,
        IRQ_ASSERT = 2'd1,
        IRQ_GAP    = 2'd2
    } irq_state_e;

    function automatic logic is_scratch(input logic [31:0] addr);
        return (addr >= REG_SCRATCH_BASE) && (addr <= REG_SCRATCH_LAST);
    endfunction

endpackage

// File: rtl/io_slave_resp_fifo.sv
// Synchronous show-ahead FIFO for read responses; head_data is the oldest entry (0 when empty).
module io_slave_resp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   iCLOCK,
    input  logic                   iRESET_SYNC,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    // A push while full is legal only when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; only the pointers and count define which entries are valid.
    always_ff @(posedge iCLOCK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_slave_responder.sv
// Device-side IO link endpoint: register file, read-response FIFO and IRQ_REQ/NUM/ACK handshake.
// Define IO_SLAVE_RESPONDER_ERRIRQ_EN to flag unmapped accesses through sticky PEND[31] (ERR).
module io_slave_responder
    import io_bus_pkg::*;
#(
    parameter logic [31:0] P_DEV_ID      = 32'h4D49_0001,
    parameter logic [31:0] P_SIZE        = 32'h0000_1000,
    parameter int          P_IRQ_LINES   = 8,
    parameter int          P_FIFO_DEPTH  = 4,
    parameter logic [5:0]  P_ERR_IRQ_NUM = 6'd31
) (
    input  logic                   iCLOCK,
    input  logic                   iRESET_SYNC,
    input  logic                   iIO_REQ,
    output logic                   oIO_BUSY,
    input  logic                   iIO_RW,
    input  logic [31:0]            iIO_ADDR,
    input  logic [31:0]            iIO_DATA,
    output logic                   oIO_REQ,
    input  logic                   iIO_BUSY,
    output logic [31:0]            oIO_DATA,
    input  logic [P_IRQ_LINES-1:0] iEVENT,
    output logic                   oIRQ_REQ,
    output logic [5:0]             oIRQ_NUM,
    input  logic                   iIRQ_ACK
);

`ifdef IO_SLAVE_RESPONDER_ERRIRQ_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic [31:0]                  addr_w;
    logic                         accept, rd_acc, wr_acc, w1c;
    logic                         mapped;
    logic [31:0]                  rd_data, pend_word, mask_word;
    logic                         fifo_full, fifo_empty;
    logic [$clog2(P_FIFO_DEPTH):0] unused_fifo_count;
    logic                         unused_addr_lsb;

    logic [P_IRQ_LINES-1:0]       ev_q, ev_rise;
    logic [P_IRQ_LINES-1:0]       pend_q, pend_clr, mask_q, irq_active;
    logic                         err_q, err_set, err_clr;
    logic [31:0]                  scratch_q [4];

    irq_state_e                   state_q, state_d;
    logic [5:0]                   irq_num_q, irq_num_d, low_idx;
    logic                         irq_ack;

    assign addr_w          = {iIO_ADDR[31:2], 2'b00};
    assign unused_addr_lsb = ^iIO_ADDR[1:0];
    assign accept          = iIO_REQ && !fifo_full;
    assign rd_acc          = accept && (iIO_RW == IO_RW_READ);
    assign wr_acc          = accept && (iIO_RW == IO_RW_WRITE);
    assign w1c             = wr_acc && (addr_w == REG_PEND);
    assign ev_rise         = iEVENT & ~ev_q;
    assign irq_active      = pend_q & mask_q;
    assign irq_ack         = (state_q == IRQ_ASSERT) && iIRQ_ACK;

    always_comb begin
        pend_word = '0;
        mask_word = '0;
        pend_word[P_IRQ_LINES-1:0] = pend_q;
        pend_word[31]              = err_q;
        mask_word[P_IRQ_LINES-1:0] = mask_q;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rd_data = '0;
        mapped  = 1'b1;
        if (addr_w == REG_ID) begin
            rd_data = P_DEV_ID;
        end else if (addr_w == REG_SIZE) begin
            rd_data = P_SIZE;
        end else if (addr_w == REG_PEND) begin
            rd_data = pend_word;
        end else if (addr_w == REG_MASK) begin
            rd_data = mask_word;
        end else if (is_scratch(addr_w)) begin
            rd_data = scratch_q[addr_w[3:2]];
        end else begin
            mapped  = 1'b0;
            rd_data = ERR_EN ? IO_UNMAPPED_DATA : '0;
        end
    end

    always_comb begin
        pend_clr = '0;
        if (w1c) begin
            pend_clr = iIO_DATA[P_IRQ_LINES-1:0];
        end
        for (int i = 0; i < P_IRQ_LINES; i++) begin
            if (irq_ack && (irq_num_q == 6'(i))) begin
                pend_clr[i] = 1'b1;
            end
        end
    end

    assign err_set = ERR_EN && accept && !mapped;
    assign err_clr = (ERR_EN && w1c && iIO_DATA[31]) || (irq_ack && (irq_num_q == P_ERR_IRQ_NUM));

    // A new rising edge outranks a same-cycle clear, hence set is OR-ed in last.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            ev_q      <= '0;
            pend_q    <= '0;
            err_q     <= 1'b0;
            mask_q    <= '0;
            scratch_q <= '{default: '0};
        end else begin
            ev_q   <= iEVENT;
            pend_q <= (pend_q & ~pend_clr) | ev_rise;
            err_q  <= err_set | (err_q & ~err_clr);
            if (wr_acc && (addr_w == REG_MASK)) begin
                mask_q <= iIO_DATA[P_IRQ_LINES-1:0];
            end
            if (wr_acc && is_scratch(addr_w)) begin
                scratch_q[addr_w[3:2]] <= iIO_DATA;
            end
        end
    end

    always_comb begin
        low_idx = '0;
        for (int i = P_IRQ_LINES - 1; i >= 0; i--) begin
            if (irq_active[i]) begin
                low_idx = 6'(i);
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q   <= IRQ_IDLE;
            irq_num_q <= '0;
        end else begin
            state_q   <= state_d;
            irq_num_q <= irq_num_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        irq_num_d = irq_num_q;
        oIRQ_REQ  = 1'b0;
        case (state_q)
            IRQ_IDLE: begin
                if (err_q) begin
                    state_d   = IRQ_ASSERT;
                    irq_num_d = P_ERR_IRQ_NUM;
                end else if (|irq_active) begin
                    state_d   = IRQ_ASSERT;
                    irq_num_d = low_idx;
                end
            end
            IRQ_ASSERT: begin
                oIRQ_REQ = 1'b1;
                if (iIRQ_ACK) begin
                    state_d = IRQ_GAP;
                end
            end
            IRQ_GAP:  state_d = IRQ_IDLE;
            default:  state_d = IRQ_IDLE;
        endcase
    end

    assign oIRQ_NUM = irq_num_q;

    io_slave_resp_fifo #(
        .WIDTH (32),
        .DEPTH (P_FIFO_DEPTH)
    ) u_resp_fifo (
        .iCLOCK      (iCLOCK),
        .iRESET_SYNC (iRESET_SYNC),
        .push        (rd_acc),
        .push_data   (rd_data),
        .pop         (!iIO_BUSY),
        .head_data   (oIO_DATA),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (unused_fifo_count)
    );

    assign oIO_BUSY = fifo_full;
    assign oIO_REQ  = !fifo_empty;

endmodule

// File: tb/tb_io_slave_responder.sv
// Self-checking bench for io_slave_responder: directed link scenarios plus random traffic
// scored against a queue/array reference model of the register map and IRQ handshake.
`timescale 1ns/1ps
module tb_io_slave_responder;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] DEV_ID   = 32'h4D49_0001;
    localparam logic [31:0] SIZE_VAL = 32'h0000_1000;
`ifdef IO_SLAVE_RESPONDER_ERRIRQ_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        iCLOCK;
    logic        iRESET_SYNC;
    logic        iIO_REQ, iIO_RW, iIO_BUSY, iIRQ_ACK;
    logic [31:0] iIO_ADDR, iIO_DATA;
    logic [7:0]  iEVENT;
    logic        oIO_BUSY, oIO_REQ, oIRQ_REQ;
    logic [31:0] oIO_DATA;
    logic [5:0]  oIRQ_NUM;

    io_slave_responder dut (
        .iCLOCK      (iCLOCK),
        .iRESET_SYNC (iRESET_SYNC),
        .iIO_REQ     (iIO_REQ),
        .oIO_BUSY    (oIO_BUSY),
        .iIO_RW      (iIO_RW),
        .iIO_ADDR    (iIO_ADDR),
        .iIO_DATA    (iIO_DATA),
        .oIO_REQ     (oIO_REQ),
        .iIO_BUSY    (iIO_BUSY),
        .oIO_DATA    (oIO_DATA),
        .iEVENT      (iEVENT),
        .oIRQ_REQ    (oIRQ_REQ),
        .oIRQ_NUM    (oIRQ_NUM),
        .iIRQ_ACK    (iIRQ_ACK)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: responses owed to the PIC, register contents, IRQ handshake phase.
    logic [31:0] exp_q [$];
    logic [31:0] m_pend;          // bit 31 is ERR
    logic [7:0]  m_mask;
    logic [31:0] m_scr [4];
    logic [7:0]  m_ev_prev;
    int          m_phase;         // 0: no request, 1: request shown, 2: gap after ACK
    logic [5:0]  m_num;
    int          m_delivered;

    function automatic logic [31:0] model_read(input logic [31:0] addr, output bit hit);
        logic [31:0] a;
        a   = {addr[31:2], 2'b00};
        hit = 1'b1;
        case (a)
            32'h00: return DEV_ID;
            32'h04: return SIZE_VAL;
            32'h08: return m_pend;
            32'h0C: return {24'b0, m_mask};
            32'h10, 32'h14, 32'h18, 32'h1C: return m_scr[(a - 32'h10) / 4];
            default: begin
                hit = 1'b0;
                return ERR_EN ? 32'hDEAD_BEEF : 32'h0;
            end
        endcase
    endfunction

    task automatic cycle();
        logic [31:0] set_bits, clr_bits, rd, a;
        logic [7:0]  act;
        bit          hit, acc, pop;
        int          next_phase;
        set_bits   = '0;
        clr_bits   = '0;
        a          = {iIO_ADDR[31:2], 2'b00};
        acc        = iIO_REQ && (exp_q.size() < DEPTH);
        pop        = (exp_q.size() > 0) && !iIO_BUSY;
        rd         = model_read(iIO_ADDR, hit);
        set_bits   = {24'b0, iEVENT & ~m_ev_prev};
        if (ERR_EN && acc && !hit) set_bits[31] = 1'b1;

        next_phase = m_phase;
        act        = m_pend[7:0] & m_mask;
        if (m_phase == 0) begin
            if (m_pend[31]) begin
                next_phase = 1;
                m_num      = 6'd31;
            end else if (act != 0) begin
                next_phase = 1;
                for (int i = 0; i < 8; i++) begin
                    if (act[i]) begin
                        m_num = 6'(i);
                        break;
                    end
                end
            end
        end else if (m_phase == 1) begin
            if (iIRQ_ACK) begin
                clr_bits[m_num] = 1'b1;
                next_phase      = 2;
            end
        end else begin
            next_phase = 0;
        end

        if (pop) begin
            void'(exp_q.pop_front());
            m_delivered++;
        end
        if (acc && !iIO_RW) exp_q.push_back(rd);
        if (acc && iIO_RW && hit) begin
            if (a == 32'h08) clr_bits |= iIO_DATA & (ERR_EN ? 32'h8000_00FF : 32'h0000_00FF);
            else if (a == 32'h0C) m_mask = iIO_DATA[7:0];
            else if (a >= 32'h10) m_scr[(a - 32'h10) / 4] = iIO_DATA;
        end
        m_pend    = (m_pend & ~clr_bits) | set_bits;
        m_ev_prev = iEVENT;
        m_phase   = next_phase;

        @(posedge iCLOCK);
        #1;
        check("busy", oIO_BUSY, exp_q.size() == DEPTH);
        check("resp_valid", oIO_REQ, exp_q.size() != 0);
        if (exp_q.size() != 0) check("resp_data", oIO_DATA, exp_q[0]);
        check("irq_req", oIRQ_REQ, m_phase == 1);
        if (m_phase == 1) check("irq_num", oIRQ_NUM, m_num);
    endtask

    task automatic do_reset();
        iRESET_SYNC = 1'b1;
        iIO_REQ = 1'b0; iIO_RW = 1'b0; iIO_ADDR = '0; iIO_DATA = '0;
        iIO_BUSY = 1'b0; iEVENT = '0; iIRQ_ACK = 1'b0;
        repeat (2) begin
            @(posedge iCLOCK);
            #1;
        end
        exp_q.delete();
        m_pend = '0; m_mask = '0; m_scr = '{default: '0};
        m_ev_prev = '0; m_phase = 0; m_num = '0;
        check("reset_io_busy", oIO_BUSY, 0);
        check("reset_io_req", oIO_REQ, 0);
        check("reset_io_data", oIO_DATA, 0);
        check("reset_irq_req", oIRQ_REQ, 0);
        check("reset_irq_num", oIRQ_NUM, 0);
        iRESET_SYNC = 1'b0;
    endtask

    task automatic req(input bit rw, input logic [31:0] addr, input logic [31:0] data);
        bit acc;
        int n;
        n = 0;
        iIO_REQ = 1'b1; iIO_RW = rw; iIO_ADDR = addr; iIO_DATA = data;
        do begin
            acc = exp_q.size() < DEPTH;
            cycle();
            n++;
        end while (!acc && n < 32);
        check("req_accepted", acc, 1);
        iIO_REQ = 1'b0;
    endtask

    task automatic wait_irq();
        int n;
        n = 0;
        while (!oIRQ_REQ && n < 16) begin
            cycle();
            n++;
        end
        check("irq_wait", oIRQ_REQ, 1);
    endtask

    task automatic ack_irq();
        iIRQ_ACK = 1'b1;
        cycle();
        iIRQ_ACK = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        iIO_BUSY = 1'b0;
        while (exp_q.size() > 0 && n < 32) begin
            cycle();
            n++;
        end
        check("drain_empty", oIO_REQ, 0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [31:0] addrs [12] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
                                32'h18, 32'h1C, 32'h08, 32'h0C, 32'h20, 32'h40};

    initial begin
        int d0;
        m_delivered = 0;
        do_reset();

        // Boot reads of SIZE and ID.
        req(0, 32'h04, 0);
        check("t1_valid", oIO_REQ, 1);
        check("t1_size", oIO_DATA, SIZE_VAL);
        req(0, 32'h00, 0);
        check("t1_id", oIO_DATA, DEV_ID);

        // Scratch write/readback and ignored RO write.
        req(1, 32'h14, 32'hA5A5_0001);
        req(0, 32'h14, 0);
        check("t2_scratch1", oIO_DATA, 32'hA5A5_0001);
        req(1, 32'h04, 32'h0);
        req(0, 32'h04, 0);
        check("t2_size_ro", oIO_DATA, SIZE_VAL);
        drain();

        // Back-pressure: fill the FIFO, then release.
        d0 = m_delivered;
        iIO_BUSY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) check("t3_busy_before4", oIO_BUSY, 0);
            req(0, 32'h10 + 32'(4 * k), 0);
        end
        check("t3_busy_after4", oIO_BUSY, 1);
        iIO_REQ = 1'b1; iIO_RW = 1'b0; iIO_ADDR = 32'h10;
        repeat (2) cycle();
        check("t3_stalled_busy", oIO_BUSY, 1);
        check("t3_head_scratch0", oIO_DATA, 32'h0);
        iIO_BUSY = 1'b0;
        req(0, 32'h10, 0);
        req(0, 32'h14, 0);
        drain();
        check("t3_resp_count", m_delivered - d0, 6);

        // Two events: lowest first, gap after ACK, then the next.
        req(1, 32'h0C, 32'hFF);
        iEVENT = 8'b0000_1010;
        cycle();
        iEVENT = '0;
        wait_irq();
        check("t4_num1", oIRQ_NUM, 1);
        ack_irq();
        check("t4_gap", oIRQ_REQ, 0);
        wait_irq();
        check("t4_num3", oIRQ_NUM, 3);
        ack_irq();
        req(0, 32'h08, 0);
        check("t4_pend_zero", oIO_DATA, 0);

        // Set beats same-cycle W1C; masked pending raises no IRQ.
        req(1, 32'h0C, 32'h0);
        iEVENT = 8'h04;
        req(1, 32'h08, 32'h4);
        iEVENT = '0;
        req(0, 32'h08, 0);
        check("t5_pend2_kept", oIO_DATA, 32'h4);
        repeat (4) cycle();
        check("t5_no_irq", oIRQ_REQ, 0);

        // Unmapped access.
        req(0, 32'h40, 0);
`ifdef IO_SLAVE_RESPONDER_ERRIRQ_EN
        check("t6_deadbeef", oIO_DATA, 32'hDEAD_BEEF);
        wait_irq();
        check("t6_err_num", oIRQ_NUM, 31);
        req(1, 32'h08, 32'h8000_0000);
        ack_irq();
        repeat (3) cycle();
        check("t6_err_cleared_irq", oIRQ_REQ, 0);
`else
        check("t6_unmapped_zero", oIO_DATA, 32'h0);
        req(1, 32'h40, 32'hFFFF_FFFF);
        repeat (3) cycle();
        check("t6_no_irq", oIRQ_REQ, 0);
`endif
        req(0, 32'h08, 0);
        check("t6_pend_word", oIO_DATA, 32'h4);
        req(1, 32'h08, 32'hFFFF_FFFF);
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            iIO_REQ  = ($urandom % 2) == 1;
            iIO_RW   = ($urandom % 2) == 1;
            iIO_ADDR = addrs[$urandom % 12] | 32'($urandom % 4);
            iIO_DATA = $urandom;
            iIO_BUSY = ($urandom % 4) == 0;
            iEVENT   = 8'($urandom);
            iIRQ_ACK = ($urandom % 3) == 0;
            cycle();
        end
        iIO_REQ = 1'b0; iEVENT = '0; iIRQ_ACK = 1'b0;
        drain();

        // Reset with responses queued and stalled.
        iIO_BUSY = 1'b1;
        req(0, 32'h10, 0);
        req(0, 32'h14, 0);
        check("mid_reset_queued", oIO_REQ, 1);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
